// File: rtl/saturn_phase_pkg.sv
// saturn_phase_pkg: phase indices, FSM states and halt-cause bits for the Saturn phase sequencer
package saturn_phase_pkg;
  localparam logic [1:0] PH_BUS_SEND = 2'd0;
  localparam logic [1:0] PH_BUS_RECV = 2'd1;
  localparam logic [1:0] PH_INST_DEC = 2'd2;
  localparam logic [1:0] PH_INST_EXE = 2'd3;
  localparam logic [1:0] PH_DEBUGGER = PH_BUS_SEND;
  localparam logic [1:0] PH_ALU_DUMP = PH_BUS_SEND;
  localparam logic [1:0] PH_ALU_PREP = PH_BUS_RECV;
  localparam logic [1:0] PH_ALU_CALC = PH_INST_DEC;
  localparam logic [1:0] PH_ALU_INIT = PH_INST_EXE;
  localparam logic [1:0] PH_ALU_SAVE = PH_INST_EXE;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;
  localparam int HC_CYCLES  = 0;
  localparam int HC_DEC_ERR = 1;
  function automatic logic [3:0] onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction
endpackage

// File: rtl/saturn_phase_decode.sv
// saturn_phase_decode: phase index to one-hot enables and named per-unit enable fan-out
module saturn_phase_decode
  import saturn_phase_pkg::*;
(
  input  logic       en,
  input  logic [1:0] ph,
  output logic [3:0] ck_ph,
  output logic       ck_bus_send,
  output logic       ck_debugger,
  output logic       ck_alu_dump,
  output logic       ck_bus_recv,
  output logic       ck_alu_prep,
  output logic       ck_inst_dec,
  output logic       ck_alu_calc,
  output logic       ck_bus_ecmd,
  output logic       ck_inst_exe,
  output logic       ck_alu_init,
  output logic       ck_alu_save
);
  assign ck_ph       = en ? onehot(ph) : 4'b0000;
  assign ck_bus_send = ck_ph[PH_BUS_SEND];
  assign ck_debugger = ck_ph[PH_DEBUGGER];
  assign ck_alu_dump = ck_ph[PH_ALU_DUMP];
  assign ck_bus_recv = ck_ph[PH_BUS_RECV];
  assign ck_alu_prep = ck_ph[PH_ALU_PREP];
  assign ck_inst_dec = ck_ph[PH_INST_DEC];
  assign ck_alu_calc = ck_ph[PH_ALU_CALC];
  assign ck_bus_ecmd = ck_ph[PH_INST_EXE];
  assign ck_inst_exe = ck_ph[PH_INST_EXE];
  assign ck_alu_init = ck_ph[PH_ALU_INIT];
  assign ck_alu_save = ck_ph[PH_ALU_SAVE];
endmodule

// File: rtl/saturn_phase_ctrl.sv
// saturn_phase_ctrl: Saturn 4-phase bus-cycle sequencer with run/pause/halt control; single-step enabled by SATURN_SINGLE_STEP_EN
module saturn_phase_ctrl
  import saturn_phase_pkg::*;
#(
  parameter int          CYCLE_W       = 32,
  parameter int unsigned DEF_MAX_CYCLE = 405
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_max_we,
  input  logic [CYCLE_W-1:0] i_max_cycle,
  input  logic               i_max_en,
  input  logic               i_bus_stall,
  input  logic               i_alu_stall_dec,
  input  logic               i_dec_error,
  output logic [3:0]         o_ck_ph,
  output logic               o_ck_bus_send,
  output logic               o_ck_debugger,
  output logic               o_ck_alu_dump,
  output logic               o_ck_bus_recv,
  output logic               o_ck_alu_prep,
  output logic               o_ck_inst_dec,
  output logic               o_ck_alu_calc,
  output logic               o_ck_bus_ecmd,
  output logic               o_ck_inst_exe,
  output logic               o_ck_alu_init,
  output logic               o_ck_alu_save,
  output logic               o_dec_stalled,
  output logic               o_alu_stalled,
  output logic               o_read_to_dec,
  output logic [CYCLE_W-1:0] o_cycle_ctr,
  output logic [1:0]         o_state,
  output logic               o_halt,
  output logic [1:0]         o_halt_cause
);
  state_t             state, state_n;
  logic [1:0]         ph, ph_n, cause, cause_n;
  logic               en, en_n, adv, hit_max, step_req;
  logic [CYCLE_W-1:0] ctr, ctr_n, budget;
`ifdef SATURN_SINGLE_STEP_EN
  assign step_req = i_step;
`else
  logic unused_step;
  assign unused_step = i_step;
  assign step_req    = 1'b0;
`endif
  assign hit_max = i_max_en && (ctr == budget + CYCLE_W'(1));
  // next state: leave IDLE only at the cycle boundary, halt on budget/decode error, pause at phase 3
  always_comb begin
    state_n = state;
    cause_n = cause;
    adv     = 1'b0;
    if (state == S_IDLE) begin
      state_n = i_run ? S_RUN : step_req ? S_STEP : S_IDLE;
      adv     = i_run | step_req;
    end else if (state == S_RUN || state == S_STEP) begin
      if (hit_max || i_dec_error) begin
        state_n             = S_HALT;
        cause_n[HC_CYCLES]  = cause[HC_CYCLES] | hit_max;
        cause_n[HC_DEC_ERR] = cause[HC_DEC_ERR] | i_dec_error;
      end else if (ph == PH_INST_EXE && (state == S_STEP || !i_run)) begin
        state_n = S_IDLE;
      end else begin
        adv = 1'b1;
      end
    end
    en_n  = adv;
    ph_n  = adv ? ph + 2'd1 : ph;
    ctr_n = (adv && ph == PH_INST_EXE) ? ctr + CYCLE_W'(1) : ctr;
  end
  // sequencer state, phase, enable and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      ph    <= PH_INST_EXE;
      en    <= 1'b0;
      ctr   <= '1;
      cause <= 2'b00;
    end else begin
      state <= state_n;
      ph    <= ph_n;
      en    <= en_n;
      ctr   <= ctr_n;
      cause <= cause_n;
    end
  end
  // cycle budget register, writable in any state
  always_ff @(posedge clk) begin
    if (!reset) budget <= CYCLE_W'(DEF_MAX_CYCLE);
    else if (i_max_we) budget <= i_max_cycle;
  end
  saturn_phase_decode u_decode (
    .en          (en),
    .ph          (ph),
    .ck_ph       (o_ck_ph),
    .ck_bus_send (o_ck_bus_send),
    .ck_debugger (o_ck_debugger),
    .ck_alu_dump (o_ck_alu_dump),
    .ck_bus_recv (o_ck_bus_recv),
    .ck_alu_prep (o_ck_alu_prep),
    .ck_inst_dec (o_ck_inst_dec),
    .ck_alu_calc (o_ck_alu_calc),
    .ck_bus_ecmd (o_ck_bus_ecmd),
    .ck_inst_exe (o_ck_inst_exe),
    .ck_alu_init (o_ck_alu_init),
    .ck_alu_save (o_ck_alu_save)
  );
  assign o_dec_stalled = i_alu_stall_dec | i_bus_stall;
  assign o_alu_stalled = i_bus_stall;
  assign o_read_to_dec = o_ck_bus_recv & ~o_dec_stalled;
  assign o_cycle_ctr   = ctr;
  assign o_state       = state;
  assign o_halt        = state == S_HALT;
  assign o_halt_cause  = cause;
endmodule

// File: tb/tb_saturn_phase_ctrl.sv
// tb_saturn_phase_ctrl: directed and randomized checks of saturn_phase_ctrl against a phase-counting reference model
module tb_saturn_phase_ctrl;
  localparam int CW = 32;
`ifdef SATURN_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  logic clk = 0, reset = 0, i_run = 0, i_step = 0, i_max_we = 0, i_max_en = 0;
  logic i_bus_stall = 0, i_alu_stall_dec = 0, i_dec_error = 0;
  logic [CW-1:0] i_max_cycle = '0;
  logic [3:0] o_ck_ph;
  logic o_ck_bus_send, o_ck_debugger, o_ck_alu_dump, o_ck_bus_recv, o_ck_alu_prep;
  logic o_ck_inst_dec, o_ck_alu_calc, o_ck_bus_ecmd, o_ck_inst_exe, o_ck_alu_init, o_ck_alu_save;
  logic o_dec_stalled, o_alu_stalled, o_read_to_dec, o_halt;
  logic [CW-1:0] o_cycle_ctr;
  logic [1:0] o_state, o_halt_cause;
  int errors = 0, checks = 0;

  // reference model: phases issued since reset, mode (0 idle,1 run,2 step,3 halt), causes, budget
  longint m_issued = 0;
  bit m_en = 0;
  int m_mode = 0;
  logic [1:0] m_cause = 0;
  logic [CW-1:0] m_budget = 405;

  always #5 clk = ~clk;

  saturn_phase_ctrl dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_step(i_step), .i_max_we(i_max_we),
    .i_max_cycle(i_max_cycle), .i_max_en(i_max_en), .i_bus_stall(i_bus_stall),
    .i_alu_stall_dec(i_alu_stall_dec), .i_dec_error(i_dec_error), .o_ck_ph(o_ck_ph),
    .o_ck_bus_send(o_ck_bus_send), .o_ck_debugger(o_ck_debugger), .o_ck_alu_dump(o_ck_alu_dump),
    .o_ck_bus_recv(o_ck_bus_recv), .o_ck_alu_prep(o_ck_alu_prep), .o_ck_inst_dec(o_ck_inst_dec),
    .o_ck_alu_calc(o_ck_alu_calc), .o_ck_bus_ecmd(o_ck_bus_ecmd), .o_ck_inst_exe(o_ck_inst_exe),
    .o_ck_alu_init(o_ck_alu_init), .o_ck_alu_save(o_ck_alu_save), .o_dec_stalled(o_dec_stalled),
    .o_alu_stalled(o_alu_stalled), .o_read_to_dec(o_read_to_dec), .o_cycle_ctr(o_cycle_ctr),
    .o_state(o_state), .o_halt(o_halt), .o_halt_cause(o_halt_cause)
  );

  function automatic logic [CW-1:0] m_ctr();
    return m_issued == 0 ? '1 : CW'((m_issued - 1) / 4);
  endfunction

  function automatic logic [3:0] m_ck();
    return m_en ? 4'(1 << int'((m_issued + 3) % 4)) : 4'b0000;
  endfunction

  task automatic tick();
    logic lim;
    logic boundary;
    @(posedge clk);
    lim = i_max_en && (m_ctr() == m_budget + CW'(1));
    boundary = (m_issued % 4) == 0;
    if (!reset) begin
      m_issued = 0; m_en = 0; m_mode = 0; m_cause = 0; m_budget = 405;
    end else begin
      if (m_mode == 1 || m_mode == 2) begin
        if (lim || i_dec_error) begin
          m_mode = 3; m_en = 0; m_cause = m_cause | {i_dec_error, lim};
        end else if (boundary && (m_mode == 2 || !i_run)) begin
          m_mode = 0; m_en = 0;
        end else begin
          m_issued++; m_en = 1;
        end
      end else if (m_mode == 0 && (i_run || (STEP_EN && i_step))) begin
        m_mode = i_run ? 1 : 2; m_issued++; m_en = 1;
      end
      if (i_max_we) m_budget = i_max_cycle;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 0; i_run = 0; i_step = 0; i_max_we = 0; i_max_en = 0; i_dec_error = 0;
    i_bus_stall = 0; i_alu_stall_dec = 0;
    repeat (3) tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) tick();
    checks++; if (o_ck_ph !== 4'b0000) begin errors++; $display("FAIL reset_ck_ph got=%b want=0000", o_ck_ph); end
    checks++; if (o_cycle_ctr !== '1) begin errors++; $display("FAIL reset_ctr got=%h want=ffffffff", o_cycle_ctr); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", o_state); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b want=0", o_halt); end
    checks++; if (o_halt_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got=%b want=00", o_halt_cause); end
  endtask

  task automatic test_run_phases();
    logic [3:0] e;
    reset = 1; i_run = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = 4'b0001 << (i % 4);
      checks++; if (o_ck_ph !== e) begin errors++; $display("FAIL run_ck_ph[%0d] got=%b want=%b", i, o_ck_ph, e); end
      checks++; if (o_cycle_ctr !== CW'(i / 4)) begin errors++; $display("FAIL run_ctr[%0d] got=%0d want=%0d", i, o_cycle_ctr, i / 4); end
      checks++;
      if ({o_ck_bus_send, o_ck_debugger, o_ck_alu_dump, o_ck_bus_recv, o_ck_alu_prep, o_ck_inst_dec,
           o_ck_alu_calc, o_ck_bus_ecmd, o_ck_inst_exe, o_ck_alu_init, o_ck_alu_save} !==
          {{3{e[0]}}, {2{e[1]}}, {2{e[2]}}, {4{e[3]}}}) begin
        errors++; $display("FAIL run_aliases[%0d] ck_ph=%b alias mismatch", i, e);
      end
    end
  endtask

  task automatic test_budget_default();
    apply_reset();
    i_max_en = 1; i_run = 1;
    for (int n = 0; n < 2000 && !o_halt; n++) tick();
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL bdef_halt got=%b want=1", o_halt); end
    checks++; if (o_cycle_ctr !== CW'(406)) begin errors++; $display("FAIL bdef_ctr got=%0d want=406", o_cycle_ctr); end
    checks++; if (o_halt_cause !== 2'b01) begin errors++; $display("FAIL bdef_cause got=%b want=01", o_halt_cause); end
    repeat (5) tick();
    checks++; if (o_ck_ph !== 4'b0000) begin errors++; $display("FAIL bdef_ck_after got=%b want=0000", o_ck_ph); end
    checks++; if (o_cycle_ctr !== CW'(406)) begin errors++; $display("FAIL bdef_ctr_frozen got=%0d want=406", o_cycle_ctr); end
    checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL bdef_state got=%0d want=3", o_state); end
  endtask

  task automatic test_budget_we();
    apply_reset();
    i_max_we = 1; i_max_cycle = 5;
    tick();
    i_max_we = 0; i_max_en = 1; i_run = 1;
    for (int n = 0; n < 200 && !o_halt; n++) tick();
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL bwe_halt got=%b want=1", o_halt); end
    checks++; if (o_cycle_ctr !== CW'(6)) begin errors++; $display("FAIL bwe_ctr got=%0d want=6", o_cycle_ctr); end
    checks++; if (o_halt_cause !== 2'b01) begin errors++; $display("FAIL bwe_cause got=%b want=01", o_halt_cause); end
  endtask

  task automatic test_dec_error();
    apply_reset();
    i_dec_error = 1;
    repeat (2) tick();
    checks++; if (o_state !== 2'd0 || o_halt_cause !== 2'b00) begin errors++; $display("FAIL decerr_idle state=%0d cause=%b want=0/00", o_state, o_halt_cause); end
    i_dec_error = 0; i_run = 1;
    for (int n = 0; n < 100 && !(o_cycle_ctr == 3 && o_ck_ph == 4'b0100); n++) tick();
    checks++; if (o_ck_ph !== 4'b0100) begin errors++; $display("FAIL decerr_reach got=%b want=0100", o_ck_ph); end
    i_dec_error = 1;
    tick();
    i_dec_error = 0;
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL decerr_halt got=%b want=1", o_halt); end
    checks++; if (o_halt_cause !== 2'b10) begin errors++; $display("FAIL decerr_cause got=%b want=10", o_halt_cause); end
    checks++; if (o_cycle_ctr !== CW'(3)) begin errors++; $display("FAIL decerr_ctr got=%0d want=3", o_cycle_ctr); end
    tick();
    checks++; if (o_ck_ph !== 4'b0000) begin errors++; $display("FAIL decerr_ck got=%b want=0000", o_ck_ph); end
  endtask

  task automatic test_pause();
    apply_reset();
    i_run = 1;
    for (int n = 0; n < 100 && !(o_cycle_ctr == 1 && o_ck_ph == 4'b0010); n++) tick();
    i_run = 0;
    tick();
    checks++; if (o_ck_ph !== 4'b0100) begin errors++; $display("FAIL pause_ph2 got=%b want=0100", o_ck_ph); end
    tick();
    checks++; if (o_ck_ph !== 4'b1000) begin errors++; $display("FAIL pause_ph3 got=%b want=1000", o_ck_ph); end
    tick();
    checks++; if (o_ck_ph !== 4'b0000 || o_state !== 2'd0) begin errors++; $display("FAIL pause_idle ck=%b state=%0d want=0000/0", o_ck_ph, o_state); end
    tick();
    checks++; if (o_ck_ph !== 4'b0000) begin errors++; $display("FAIL pause_hold got=%b want=0000", o_ck_ph); end
    i_run = 1;
    tick();
    checks++; if (o_ck_ph !== 4'b0001 || o_cycle_ctr !== CW'(2)) begin errors++; $display("FAIL pause_resume ck=%b ctr=%0d want=0001/2", o_ck_ph, o_cycle_ctr); end
  endtask

  task automatic test_stalls();
    apply_reset();
    i_run = 1;
    for (int n = 0; n < 20 && o_ck_ph != 4'b0010; n++) tick();
    checks++; if (o_read_to_dec !== 1'b1) begin errors++; $display("FAIL stall_read_free got=%b want=1", o_read_to_dec); end
    i_bus_stall = 1;
    #1;
    checks++; if ({o_dec_stalled, o_alu_stalled, o_read_to_dec} !== 3'b110) begin errors++; $display("FAIL stall_bus got=%b want=110", {o_dec_stalled, o_alu_stalled, o_read_to_dec}); end
    tick();
    checks++; if (o_ck_ph !== 4'b0100) begin errors++; $display("FAIL stall_advance got=%b want=0100", o_ck_ph); end
    i_bus_stall = 0; i_alu_stall_dec = 1;
    #1;
    checks++; if ({o_dec_stalled, o_alu_stalled} !== 2'b10) begin errors++; $display("FAIL stall_alu got=%b want=10", {o_dec_stalled, o_alu_stalled}); end
    i_alu_stall_dec = 0;
  endtask

  task automatic test_step();
    logic [3:0] e;
    apply_reset();
    i_step = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      i_step = (i == 1);
      e = STEP_EN ? 4'(4'b0001 << i) : 4'b0000;
      checks++; if (o_ck_ph !== e) begin errors++; $display("FAIL step_ck[%0d] got=%b want=%b", i, o_ck_ph, e); end
      checks++; if (o_state !== (STEP_EN ? 2'd2 : 2'd0)) begin errors++; $display("FAIL step_state[%0d] got=%0d", i, o_state); end
    end
    i_step = 0;
    tick();
    checks++; if (o_ck_ph !== 4'b0000 || o_state !== 2'd0) begin errors++; $display("FAIL step_end ck=%b state=%0d want=0000/0", o_ck_ph, o_state); end
    checks++; if (o_cycle_ctr !== (STEP_EN ? CW'(0) : '1)) begin errors++; $display("FAIL step_ctr got=%h", o_cycle_ctr); end
    tick();
    checks++; if (o_ck_ph !== 4'b0000) begin errors++; $display("FAIL step_quiet got=%b want=0000", o_ck_ph); end
  endtask

  task automatic test_random();
    logic exp_rd;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      reset = $urandom_range(0, 79) != 0;
      i_run = $urandom_range(0, 9) < 6;
      i_step = $urandom_range(0, 7) == 0;
      i_dec_error = $urandom_range(0, 149) == 0;
      i_max_we = $urandom_range(0, 39) == 0;
      i_max_cycle = ($urandom_range(0, 7) == 7) ? '1 : CW'($urandom_range(0, 6));
      i_max_en = $urandom_range(0, 3) != 0;
      i_bus_stall = $urandom_range(0, 1) == 1;
      i_alu_stall_dec = $urandom_range(0, 1) == 1;
      #1;
      exp_rd = m_ck() == 4'b0010 && !i_bus_stall && !i_alu_stall_dec;
      checks++;
      if ({o_dec_stalled, o_alu_stalled, o_read_to_dec} !== {i_bus_stall | i_alu_stall_dec, i_bus_stall, exp_rd}) begin
        errors++; $display("FAIL rnd_stall[%0d] got=%b want=%b", n, {o_dec_stalled, o_alu_stalled, o_read_to_dec}, {i_bus_stall | i_alu_stall_dec, i_bus_stall, exp_rd});
      end
      tick();
      checks++; if (o_ck_ph !== m_ck()) begin errors++; $display("FAIL rnd_ck[%0d] got=%b want=%b", n, o_ck_ph, m_ck()); end
      checks++; if (o_cycle_ctr !== m_ctr()) begin errors++; $display("FAIL rnd_ctr[%0d] got=%h want=%h", n, o_cycle_ctr, m_ctr()); end
      checks++; if (o_state !== 2'(m_mode)) begin errors++; $display("FAIL rnd_state[%0d] got=%0d want=%0d", n, o_state, m_mode); end
      checks++; if (o_halt_cause !== m_cause) begin errors++; $display("FAIL rnd_cause[%0d] got=%b want=%b", n, o_halt_cause, m_cause); end
      checks++; if (o_halt !== (m_mode == 3)) begin errors++; $display("FAIL rnd_halt[%0d] got=%b want=%b", n, o_halt, m_mode == 3); end
    end
  endtask

  initial begin
    test_reset();
    test_run_phases();
    test_budget_default();
    test_budget_we();
    test_dec_error();
    test_pause();
    test_stalls();
    test_step();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
